// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM instruction fetch unit.
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    // Words owned by the unit once this cycle's pop has been taken out.
    function automatic logic [CNT_W:0] occupancy(
        input logic [CNT_W-1:0] count,
        input logic             inflight,
        input logic             pop
    );
        return {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    endfunction

endpackage

// File: rtl/rom_fetch_skid_fifo.sv
// Two-entry output buffer holding {pc, word} pairs for the fetch unit.
module fetch_skid_fifo
    import rom_fetch_pkg::*;
#(
    parameter int W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [W-1:0]     mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;

    assign full    = (count == CNT_W'(BUF_DEPTH));
    assign do_push = push & (~full | pop);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_fetch.sv
// Sequential fetch from a synchronous ROM with redirect, halt and a 2-word buffer.
// Define ROM_FETCH_PERF_EN to add the perf_stall_cnt output.
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter int          DWIDTH   = 16,
    parameter int          AWIDTH   = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_en,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_dout,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc
`ifdef ROM_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [AWIDTH-1:0] PC0 = AWIDTH'(RESET_PC);

    state_t                    state;
    logic [AWIDTH-1:0]         pc;
    logic [AWIDTH-1:0]         inflight_pc;
    logic                      inflight;
    logic                      push;
    logic                      pop;
    logic                      empty;
    logic [CNT_W-1:0]          count;
    logic [AWIDTH+DWIDTH-1:0]  head;

    assign pop         = instr_valid & instr_ready;
    assign push        = inflight & ~redirect_valid;
    assign instr_valid = ~empty & ~redirect_valid;
    assign {instr_pc, instr} = head;
    assign rom_addr    = pc;

    // Issue only while the buffer can still absorb the returning word.
    assign rom_en = (state == RUN) & ~halt_req & ~redirect_valid
                  & (occupancy(count, inflight, pop) <= (CNT_W + 1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= PC0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= rom_en;
            if (rom_en) begin
                inflight_pc <= pc;
                pc          <= pc + 1'b1;
            end
            if (redirect_valid) begin
                pc    <= redirect_pc;
                state <= RUN;
            end else begin
                unique case (state)
                    BOOT:    state <= RUN;
                    RUN:     if (halt_req) state <= HALTED;
                    HALTED:  state <= HALTED;
                    default: state <= BOOT;
                endcase
            end
        end
    end

    fetch_skid_fifo #(
        .W(AWIDTH + DWIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({inflight_pc, rom_dout}),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

`ifdef ROM_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if (instr_valid & ~instr_ready & (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rom_fetch.sv
// Directed scoreboard bench for rom_fetch (default and RESET_PC=0xFFF instances).
module tb_rom_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [15:0] rom_dout;
    logic        halt_req;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [11:0] instr_pc;

    logic        rst2_n;
    logic        rom_en2;
    logic [11:0] rom_addr2;
    logic [15:0] rom_dout2;
    logic        instr_valid2;
    logic [15:0] instr2;
    logic [11:0] instr_pc2;

`ifdef ROM_FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_stall_cnt2;
`endif

    int errors = 0;
    int checks = 0;
    logic [27:0] exp_q [$];
    logic [27:0] got;

    rom_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef ROM_FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    rom_fetch #(
        .RESET_PC(4095)
    ) dut2 (
        .clk            (clk),
        .rst_n          (rst2_n),
        .rom_en         (rom_en2),
        .rom_addr       (rom_addr2),
        .rom_dout       (rom_dout2),
        .halt_req       (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (12'h000),
        .instr_valid    (instr_valid2),
        .instr_ready    (1'b1),
        .instr          (instr2),
        .instr_pc       (instr_pc2)
`ifdef ROM_FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt2)
`endif
    );

    function automatic logic [15:0] rom_word(input logic [11:0] a);
        case (a)
            12'd0:   return 16'h0004;
            12'd1:   return 16'h3400;
            12'd2:   return 16'h3900;
            12'd3:   return 16'hA000;
            default: return {4'hC, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom_word(rom_addr);
        if (rom_en2) rom_dout2 <= rom_word(rom_addr2);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [11:0] start);
        logic [11:0] a;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            a = start + 12'(i);
            exp_q.push_back({a, rom_word(a)});
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Every accepted word must be the next one the bench expects.
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra observed=0x%0h expected=none",
                       {instr_pc, instr});
            end
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                chk("sb_word", 32'({instr_pc, instr}), 32'(got));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rst2_n = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 12'h000;
        instr_ready = 1'b1;
        exp_q.delete();

        step(3);
        smp();
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_addr2", 32'(rom_addr2), 32'hFFF);
`ifdef ROM_FETCH_PERF_EN
        chk("rst_perf", perf_stall_cnt, 32'd0);
`endif

        // Basic stream and first-word latency
        step();
        load(12'd0);
        rst_n = 1'b1;
        smp();
        chk("boot_rom_en", 32'(rom_en), 32'd0);
        step();
        smp();
        chk("c1_rom_en", 32'(rom_en), 32'd1);
        chk("c1_addr", 32'(rom_addr), 32'd0);
        chk("c1_valid", 32'(instr_valid), 32'd0);
        step();
        smp();
        chk("c2_valid", 32'(instr_valid), 32'd0);
        chk("c2_addr", 32'(rom_addr), 32'd1);
        step();
        smp();
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_word", 32'({instr_pc, instr}), 32'h0000004);
        for (int i = 0; i < 3; i++) begin
            step();
            smp();
            chk("stream_valid", 32'(instr_valid), 32'd1);
        end

        // Backpressure: buffer fills, issue stops, head holds
        step();
        redirect_valid = 1'b1;
        redirect_pc = 12'd0;
        instr_ready = 1'b0;
        load(12'd0);
        smp();
        chk("redir_rom_en", 32'(rom_en), 32'd0);
        chk("redir_valid", 32'(instr_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        step(2);
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_rom_en", 32'(rom_en), 32'd0);
            chk("hold_word", 32'({instr_pc, instr}), 32'h0000004);
            step();
        end
        instr_ready = 1'b1;
        step(6);

        // Squash the in-flight pc 1 by redirecting to 3
        redirect_valid = 1'b1;
        redirect_pc = 12'd0;
        load(12'd0);
        step();
        redirect_valid = 1'b0;
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 12'd3;
        load(12'd3);
        smp();
        chk("sq_rom_en", 32'(rom_en), 32'd0);
        chk("sq_valid", 32'(instr_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        step(2);
        smp();
        chk("sq_first", 32'({instr_pc, instr}), 32'h003A000);
        chk("sq_first_valid", 32'(instr_valid), 32'd1);

        // Halt, drain, no self-resume
        step(3);
        halt_req = 1'b1;
        smp();
        chk("halt_rom_en", 32'(rom_en), 32'd0);
        step();
        smp();
        chk("halt_next_rom_en", 32'(rom_en), 32'd0);
        step(4);
        smp();
        chk("halt_drained", 32'(instr_valid), 32'd0);
        step();
        halt_req = 1'b0;
        step(3);
        smp();
        chk("unhalt_rom_en", 32'(rom_en), 32'd0);
        chk("unhalt_valid", 32'(instr_valid), 32'd0);

        // Redirect wins over halt; halt lands next cycle
        step();
        redirect_valid = 1'b1;
        redirect_pc = 12'd0;
        halt_req = 1'b1;
        load(12'd0);
        smp();
        chk("rh_rom_en", 32'(rom_en), 32'd0);
        step();
        redirect_valid = 1'b0;
        smp();
        chk("rh_halt_rom_en", 32'(rom_en), 32'd0);
        step();
        halt_req = 1'b0;
        smp();
        chk("rh_halted_rom_en", 32'(rom_en), 32'd0);
        step(2);
        smp();
        chk("rh_valid", 32'(instr_valid), 32'd0);

        // Redirect resumes from 0
        step();
        redirect_valid = 1'b1;
        redirect_pc = 12'd0;
        load(12'd0);
        step();
        redirect_valid = 1'b0;
        step(2);
        smp();
        chk("resume_valid", 32'(instr_valid), 32'd1);
        chk("resume_word", 32'({instr_pc, instr}), 32'h0000004);

        // Reset mid-stream, then stall counting
        step(2);
        instr_ready = 1'b0;
        rst_n = 1'b0;
        smp();
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_rom_en", 32'(rom_en), 32'd0);
        chk("mrst_word", 32'({instr_pc, instr}), 32'd0);
        chk("mrst_addr", 32'(rom_addr), 32'd0);
`ifdef ROM_FETCH_PERF_EN
        chk("mrst_perf", perf_stall_cnt, 32'd0);
`endif
        step();
        load(12'd0);
        rst_n = 1'b1;
        step(3);
        smp();
        chk("mrst_first_valid", 32'(instr_valid), 32'd1);
        chk("mrst_first_word", 32'({instr_pc, instr}), 32'h0000004);
        step(4);
        instr_ready = 1'b1;
        smp();
`ifdef ROM_FETCH_PERF_EN
        chk("perf_stall4", perf_stall_cnt, 32'd4);
`endif
        step(4);

        // pc wrap from 0xFFF
        rst2_n = 1'b1;
        smp();
        chk("w_boot_rom_en", 32'(rom_en2), 32'd0);
        step();
        smp();
        chk("w_en1", 32'(rom_en2), 32'd1);
        chk("w_addr1", 32'(rom_addr2), 32'hFFF);
        step();
        smp();
        chk("w_addr2", 32'(rom_addr2), 32'h000);
        step();
        smp();
        chk("w_addr3", 32'(rom_addr2), 32'h001);
        chk("w_valid", 32'(instr_valid2), 32'd1);
        chk("w_word", 32'({instr_pc2, instr2}), 32'hFFFCFFF);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_fetch.md
ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 Parameter DWIDTH, default 16, SHALL set the instruction word width.
REQ-002 Parameter AWIDTH, default 12, SHALL set the ROM address width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rom_en  out  1  read request to the synchronous ROM.
REQ-007 rom_addr  out  AWIDTH  ROM read address, qualified by rom_en.
REQ-008 rom_dout  in  DWIDTH  ROM data, valid exactly one cycle after rom_en.
REQ-009 halt_req  in  1  level; stop issuing new fetches.
REQ-010 redirect_valid  in  1  one-cycle jump request.
REQ-011 redirect_pc  in  AWIDTH  jump target, qualified by redirect_valid.
REQ-012 instr_valid  out  1  instr and instr_pc are valid.
REQ-013 instr_ready  in  1  consumer accepts the word.
REQ-014 instr  out  DWIDTH  fetched word.
REQ-015 instr_pc  out  AWIDTH  address of instr.

Function
REQ-016 FSM states SHALL be BOOT, RUN and HALTED.
REQ-017 BOOT SHALL last exactly one cycle after rst_n deasserts with rom_en=0, then move to RUN.
REQ-018 RUN SHALL move to HALTED when halt_req=1 and redirect_valid=0.
REQ-019 HALTED SHALL move to RUN only on redirect_valid=1; halt_req deassertion alone SHALL NOT resume fetching.
REQ-020 An internal 2-entry output buffer plus one in-flight flag SHALL bound outstanding words to 2.
REQ-021 In RUN, rom_en SHALL be 1 iff halt_req=0, redirect_valid=0 and (buffered + in-flight - pop) <= 1, where pop = instr_valid & instr_ready.
REQ-022 rom_addr SHALL equal the pc register; pc SHALL increment by 1 on each issue and wrap from 2^AWIDTH-1 to 0.
REQ-023 A word issued in cycle N SHALL be written into the buffer at the end of cycle N+1 with its pc, unless squashed.
REQ-024 With instr_ready held at 1 and no redirect, sustained throughput SHALL be one word per cycle with 2-cycle issue-to-instr_valid latency.
REQ-025 instr_valid SHALL be 1 iff the buffer is non-empty and redirect_valid=0; instr, instr_pc SHALL be the oldest entry and hold stable while instr_valid=1 and instr_ready=0.
REQ-026 On redirect_valid=1, in any state except BOOT, the buffer SHALL be cleared, the in-flight word squashed, pc <= redirect_pc, rom_en=0, and state <= RUN.
REQ-027 A redirect_valid asserted during BOOT SHALL be honoured identically on the BOOT->RUN transition.
REQ-028 Simultaneous redirect_valid and halt_req SHALL give priority to redirect; halt takes effect the following cycle if still asserted.
REQ-029 In HALTED, an in-flight word SHALL still be delivered and buffered words SHALL drain normally.
REQ-030 No word SHALL ever be dropped or duplicated except by redirect squash.

Reset
REQ-031 While rst_n=0: state=BOOT, pc=RESET_PC, buffer empty, in-flight=0, rom_en=0, instr_valid=0, instr=0, instr_pc=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered and in-flight words immediately.

Configuration
REQ-033 With macro ROM_FETCH_PERF_EN defined, an output perf_stall_cnt [31:0] SHALL count cycles with instr_valid=1 and instr_ready=0, saturating at 0xFFFFFFFF, reset to 0.
REQ-034 Without ROM_FETCH_PERF_EN, the port and counter SHALL NOT exist.

Structure
REQ-035 A shared package rom_fetch_pkg SHALL hold the FSM state typedef and the buffer depth constant (2).
REQ-036 The 2-entry buffer SHALL be a sub-module fetch_skid_fifo storing {pc, word}.

Verification
REQ-037 ROM = {0x0004, 0x3400, 0x3900, 0xA000}, ready=1 -> instr sequence 0x0004@0, 0x3400@1, 0x3900@2, 0xA000@3; first instr_valid 3 cycles after rst_n rises.
REQ-038 Ready held low 5 cycles after first valid -> exactly 2 buffered words, rom_en=0, instr stable at 0x0004@0; on release, sequence resumes at pc 1 without loss.
REQ-039 Redirect to 3 while in-flight word at pc 1 -> pc 1 and 2 never appear; next valid word is 0xA000@3.
REQ-040 halt_req=1 in RUN -> rom_en=0 next cycle, in-flight word delivered; halt_req=0 alone does not resume; redirect to 0 resumes at 0x0004@0.
REQ-041 RESET_PC = 2^AWIDTH-1 -> pc sequence 0xFFF, 0x000, 0x001.
REQ-042 With ROM_FETCH_PERF_EN, 4 stalled cycles -> perf_stall_cnt = 4; rst_n pulse mid-stream -> all outputs return to reset values.
